// File: rtl/wb_stage_pipe.sv
// ============================================================================
// wb_stage_pipe : registered write-back stage (source mux, load extract, RF port)
// Optional retire counter enabled by macro WB_RETIRE_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module wb_stage_pipe #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               hold,
  input  logic               flush,
  input  logic [XLEN-1:0]    alu_result,
  input  logic [XLEN-1:0]    mem_data,
  input  logic [XLEN-1:0]    pc_plus4,
  input  logic [XLEN-1:0]    imm,
  input  logic [1:0]         wb_sel,
  input  logic [1:0]         ld_size,
  input  logic               ld_unsigned,
  input  logic [RADDR_W-1:0] rd,
  input  logic               rd_we,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               ld_misalign,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam int OFF_W = $clog2(XLEN / 8);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [OFF_W-1:0] offset;
  logic [XLEN-1:0]  lane;
  logic [XLEN-1:0]  lane_mask;
  logic [6:0]       lane_bits;
  logic             lane_sign;
  logic [XLEN-1:0]  load_val;
  logic             misalign;
  logic [XLEN-1:0]  src;
  logic             capture;
  logic             retire;

  assign in_ready = ~hold;
  assign capture  = in_valid & ~hold;
  assign retire   = capture & ~flush;

  assign offset = alu_result[OFF_W-1:0];
  assign lane   = mem_data >> {offset, 3'b000};

  // Extension is done by masking: bits above the lane come from the sign bit or zero.
  always_comb begin
    lane_bits = 7'(XLEN);
    lane_sign = lane[XLEN-1];
    case (ld_size)
      SZ_BYTE: begin lane_bits = 7'd8;  lane_sign = lane[7];  end
      SZ_HALF: begin lane_bits = 7'd16; lane_sign = lane[15]; end
      SZ_WORD: begin lane_bits = 7'd32; lane_sign = lane[31]; end
      default: begin lane_bits = 7'(XLEN); lane_sign = lane[XLEN-1]; end
    endcase
    lane_mask = ~({XLEN{1'b1}} << lane_bits);
    load_val  = (lane & lane_mask) |
                ((~ld_unsigned & lane_sign) ? ~lane_mask : '0);
  end

  always_comb begin
    misalign = 1'b0;
    if (wb_sel == SEL_MEM) begin
      case (ld_size)
        SZ_BYTE: misalign = 1'b0;
        SZ_HALF: misalign = offset[0];
        SZ_WORD: misalign = (offset[1:0] != 2'b00);
        default: misalign = (offset != '0) || (XLEN == 32);
      endcase
    end
  end

  always_comb begin
    case (wb_sel)
      SEL_ALU:  src = alu_result;
      SEL_MEM:  src = load_val;
      SEL_LINK: src = pc_plus4;
      default:  src = imm;
    endcase
  end

  // Held cycles keep address/data but never repeat the write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      ld_misalign <= 1'b0;
    end else if (hold) begin
      rf_we <= 1'b0;
    end else if (retire) begin
      rf_we       <= rd_we & (rd != '0) & ~misalign;
      rf_waddr    <= rd;
      rf_wdata    <= src;
      ld_misalign <= misalign;
    end else begin
      rf_we       <= 1'b0;
      ld_misalign <= 1'b0;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`else
  assign retire_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
// ============================================================================
// tb_wb_stage_pipe : directed self-checking bench for wb_stage_pipe (XLEN=32)
// Counter checks depend on WB_RETIRE_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] mem_data = '0;
  logic [31:0] pc_plus4 = '0;
  logic [31:0] imm = '0;
  logic [1:0]  wb_sel = 2'b00;
  logic [1:0]  ld_size = 2'b00;
  logic        ld_unsigned = 1'b0;
  logic [4:0]  rd = '0;
  logic        rd_we = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ld_misalign;
  logic [63:0] retire_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_stage_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .flush(flush), .alu_result(alu_result), .mem_data(mem_data),
    .pc_plus4(pc_plus4), .imm(imm), .wb_sel(wb_sel), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .rd(rd), .rd_we(rd_we), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ld_misalign(ld_misalign),
    .retire_cnt(retire_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] sel, input logic [31:0] alu,
                       input logic [1:0] size, input logic uns,
                       input logic [4:0] dst, input logic we);
    in_valid    = 1'b1;
    wb_sel      = sel;
    alu_result  = alu;
    ld_size     = size;
    ld_unsigned = uns;
    rd          = dst;
    rd_we       = we;
  endtask

  initial begin
    // Reset state (asynchronous, before any clock edge)
    #2;
    chk("rst_we",    64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_mis",   64'(ld_misalign), 64'd0);
    chk("rst_cnt",   retire_cnt, 64'd0);
    #10;
    rst = 1'b0;

    // ALU path
    instr(2'b00, 32'h1234_5678, 2'b00, 1'b0, 5'd5, 1'b1);
    tick();
    chk("alu_we",    64'(rf_we), 64'd1);
    chk("alu_waddr", 64'(rf_waddr), 64'd5);
    chk("alu_wdata", 64'(rf_wdata), 64'h1234_5678);
    chk("ready",     64'(in_ready), 64'd1);

    // Byte / half / word loads from 0x80FF_7F01
    mem_data = 32'h80FF_7F01;
    instr(2'b01, 32'h0000_2003, 2'b00, 1'b0, 5'd6, 1'b1);
    tick();
    chk("lb_off3",  64'(rf_wdata), 64'hFFFF_FF80);
    chk("lb_we",    64'(rf_we), 64'd1);
    instr(2'b01, 32'h0000_2003, 2'b00, 1'b1, 5'd6, 1'b1);
    tick();
    chk("lbu_off3", 64'(rf_wdata), 64'h0000_0080);
    instr(2'b01, 32'h0000_2001, 2'b00, 1'b0, 5'd6, 1'b1);
    tick();
    chk("lb_off1",  64'(rf_wdata), 64'h0000_007F);
    instr(2'b01, 32'h0000_2002, 2'b01, 1'b0, 5'd6, 1'b1);
    tick();
    chk("lh_off2",  64'(rf_wdata), 64'hFFFF_80FF);
    instr(2'b01, 32'h0000_2002, 2'b01, 1'b1, 5'd6, 1'b1);
    tick();
    chk("lhu_off2", 64'(rf_wdata), 64'h0000_80FF);

    // Misaligned half then aligned word
    instr(2'b01, 32'h0000_1001, 2'b01, 1'b0, 5'd7, 1'b1);
    tick();
    chk("mis_h_we",  64'(rf_we), 64'd0);
    chk("mis_h_mis", 64'(ld_misalign), 64'd1);
    instr(2'b01, 32'h0000_1000, 2'b10, 1'b0, 5'd7, 1'b1);
    tick();
    chk("lw_mis",   64'(ld_misalign), 64'd0);
    chk("lw_we",    64'(rf_we), 64'd1);
    chk("lw_wdata", 64'(rf_wdata), 64'h80FF_7F01);
    instr(2'b01, 32'h0000_1002, 2'b10, 1'b0, 5'd7, 1'b1);
    tick();
    chk("mis_w_mis", 64'(ld_misalign), 64'd1);
    instr(2'b01, 32'h0000_1000, 2'b11, 1'b0, 5'd7, 1'b1);
    tick();
    chk("ld32_mis", 64'(ld_misalign), 64'd1);
    chk("ld32_we",  64'(rf_we), 64'd0);
    // Size ignored off the MEM path: odd address with "dword" size on ALU select
    instr(2'b00, 32'h0000_1003, 2'b11, 1'b0, 5'd7, 1'b1);
    tick();
    chk("alu_nomis", 64'(ld_misalign), 64'd0);
    chk("alu_nomis_we", 64'(rf_we), 64'd1);

    // x0, link, immediate
    instr(2'b00, 32'h0000_00AA, 2'b00, 1'b0, 5'd0, 1'b1);
    tick();
    chk("x0_we", 64'(rf_we), 64'd0);
    pc_plus4 = 32'h0000_0104;
    instr(2'b10, 32'h0000_00AA, 2'b00, 1'b0, 5'd1, 1'b1);
    tick();
    chk("link_wdata", 64'(rf_wdata), 64'h104);
    chk("link_waddr", 64'(rf_waddr), 64'd1);
    imm = 32'hABCD_E000;
    instr(2'b11, 32'h0000_00AA, 2'b00, 1'b0, 5'd2, 1'b1);
    tick();
    chk("imm_wdata", 64'(rf_wdata), 64'hABCD_E000);
    instr(2'b00, 32'h0000_00AA, 2'b00, 1'b0, 5'd3, 1'b0);
    tick();
    chk("nowe_we", 64'(rf_we), 64'd0);

    // Hold for 3 cycles after a write
    instr(2'b00, 32'h0000_0055, 2'b00, 1'b0, 5'd9, 1'b1);
    tick();
    chk("pre_hold_we", 64'(rf_we), 64'd1);
    hold = 1'b1;
    instr(2'b00, 32'h0000_0066, 2'b00, 1'b0, 5'd10, 1'b1);
    #1;
    chk("hold_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_we",    64'(rf_we), 64'd0);
      chk("hold_waddr", 64'(rf_waddr), 64'd9);
      chk("hold_wdata", 64'(rf_wdata), 64'h55);
    end
    hold = 1'b0;

    // Flush with valid input
    flush = 1'b1;
    tick();
    chk("flush_we",  64'(rf_we), 64'd0);
    chk("flush_mis", 64'(ld_misalign), 64'd0);
    flush = 1'b0;

    // Flush & hold together: nothing captured, flush dropped afterwards
    instr(2'b00, 32'h0000_0077, 2'b00, 1'b0, 5'd11, 1'b1);
    tick();
    chk("pre_fh_we", 64'(rf_we), 64'd1);
    hold = 1'b1;
    flush = 1'b1;
    instr(2'b00, 32'h0000_0088, 2'b00, 1'b0, 5'd12, 1'b1);
    tick();
    chk("fh_we",    64'(rf_we), 64'd0);
    chk("fh_waddr", 64'(rf_waddr), 64'd11);
    chk("fh_wdata", 64'(rf_wdata), 64'h77);
    hold = 1'b0;
    flush = 1'b0;
    tick();
    chk("post_fh_we",    64'(rf_we), 64'd1);
    chk("post_fh_wdata", 64'(rf_wdata), 64'h88);

    // Idle: bubble
    in_valid = 1'b0;
    tick();
    chk("idle_we", 64'(rf_we), 64'd0);

    // Retire counter: reset, then 10 valid instructions of which 2 flushed
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      instr(2'b00, 32'(i), 2'b00, 1'b0, 5'd4, (i % 2) == 0);
      flush = (i == 3) || (i == 7);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_8", retire_cnt, 64'd8);
`else
    chk("cnt_off", retire_cnt, 64'd0);
`endif

    // Asynchronous reset between edges during a write
    instr(2'b00, 32'hDEAD_BEEF, 2'b00, 1'b0, 5'd13, 1'b1);
    tick();
    chk("pre_rst_we", 64'(rf_we), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we",    64'(rf_we), 64'd0);
    chk("arst_waddr", 64'(rf_waddr), 64'd0);
    chk("arst_wdata", 64'(rf_wdata), 64'd0);
    chk("arst_mis",   64'(ld_misalign), 64'd0);
    chk("arst_cnt",   retire_cnt, 64'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
